id_fwd_stage: RTL and testbench
===============================

Name: id_fwd_stage

Overview:
Parametrised successor to the combinational decode stage. It resolves both source operands through an N-channel forwarding network and detects load-use hazards itself. It registers the decode result into an ID/EX pipeline latch with a valid/ready handshake and evaluates branches on forwarded operands. It sits between IF/ID and EX and sends stall_request back to the pipeline control.

Parameters:
DATA_WIDTH, 32, operand/register data width
ADDR_WIDTH, 32, PC/branch address width
REG_ADDR_WIDTH, 5, register index width; index 0 is hard-wired zero
FWD_CH, 2, number of forwarding channels; channel 0 = youngest (EX), higher index = older
CNT_WIDTH, 16, width of saturating stall-cycle counter

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
id_valid  in  1  instruction present in ID
id_ready  out  1  ID instruction consumed this cycle
id_pc  in  ADDR_WIDTH  instruction address
br_type  in  2  0 none, 1 BEQ, 2 BNE, 3 unconditional
br_target  in  ADDR_WIDTH  precomputed branch target
rd_en_1 / rd_en_2  in  1  source read enables
rd_addr_1 / rd_addr_2  in  REG_ADDR_WIDTH  source indices
rd_data_1 / rd_data_2  in  DATA_WIDTH  RegFile read data
fwd_we  in  FWD_CH  channel writes a register
fwd_load  in  FWD_CH  channel holds a load; data not yet valid
fwd_addr  in  FWD_CH*REG_ADDR_WIDTH  packed destination indices, channel 0 in LSBs
fwd_data  in  FWD_CH*DATA_WIDTH  packed result data
flush  in  1  squash ID/EX contents
ex_ready  in  1  EX accepts latch contents
ex_valid  out  1  latch holds a valid instruction
ex_pc  out  ADDR_WIDTH  latched PC
ex_op1 / ex_op2  out  DATA_WIDTH  latched resolved operands
stall_request  out  1  load-use hazard (combinational)
branch_flag  out  1  taken-branch pulse
branch_addr  out  ADDR_WIDTH  taken-branch target
stall_cnt  out  CNT_WIDTH  saturating count of stall cycles

Behaviour:
- Operand resolution (combinational, per source s):
  - rd_en_s=0 or rd_addr_s=0: value 0, no hazard.
  - Otherwise, the lowest-index channel with fwd_we=1 and a matching address wins.
  - If the winning channel has fwd_load=1, hazard_s=1; otherwise the value is fwd_data of that channel.
  - No matching channel: value is rd_data_s.
- hazard = id_valid & (hazard_1 | hazard_2). stall_request = hazard.
- advance = ex_ready | ~ex_valid.
- id_ready = id_valid & ~hazard & advance & ~flush.
- Latch update:
  - On advance, ex_valid <= id_ready & ~squash. On id_ready, ex_pc/ex_op1/ex_op2 are loaded.
  - A hazard while advance=1 inserts a bubble (ex_valid<=0).
  - With advance=0, all latch outputs hold.
- Branch evaluation on resolved operands, only when id_ready=1 and not squashing:
  - Taken when br_type=3, when br_type=1 and op1==op2, or when br_type=2 and op1!=op2.
  - On a taken branch, branch_flag<=1 for exactly one cycle (latency 1 after acceptance) and branch_addr<=br_target.
  - branch_addr holds its value until the next taken branch.
- State machine RUN/SQUASH (see Optional Feature). Without the feature, a taken branch moves RUN->SQUASH. In SQUASH, the next instruction with id_ready=1 is consumed with ex_valid<=0 and no branch evaluation, then the state returns to RUN.
- stall_cnt increments each cycle that stall_request=1 and saturates at all-ones. It is unaffected by flush.
- Priority: rst > flush > normal operation.
  - flush: ex_valid<=0, branch_flag<=0, state<=RUN. A branch accepted in the same cycle is dropped.
- Reset values: ex_valid=0, ex_pc=0, ex_op1=0, ex_op2=0, branch_flag=0, branch_addr=0, stall_cnt=0, state=RUN.
- Reset mid-stall clears everything; a hazard in the reset cycle is not counted.

Optional Feature:
DELAY_SLOT_EN: when defined, the instruction following a taken branch executes normally (MIPS delay slot). The SQUASH state is never entered. When undefined, that instruction is consumed and replaced by a bubble as described above.

Test Plan:
- Forward priority: ch0 writes r3=0x11, ch1 writes r3=0x22, rd_addr_1=3 -> ex_op1=0x11 next cycle. ch0 disabled -> 0x22. No match -> rd_data_1.
- Load-use: fwd_load[0]=1, fwd_addr ch0=5, rd_addr_2=5 for 2 cycles -> stall_request=1 and id_ready=0 for 2 cycles, ex_valid=0, stall_cnt=2. fwd_load drops -> instruction accepted.
- r0 rule: rd_addr_1=0 with ch0 writing r0=0xFFFF_FFFF and fwd_load=1 -> ex_op1=0, no stall.
- BEQ taken on forwarded values (op1=op2=7), br_target=0x100 -> branch_flag pulses 1 cycle later, branch_addr=0x100. Next instruction: ex_valid=1 with DELAY_SLOT_EN, ex_valid=0 without.
- Backpressure: ex_valid=1, ex_ready=0 for 3 cycles -> id_ready=0 and latch outputs unchanged. ex_ready=1 -> new instruction loaded.
- flush in the same cycle as an accepted taken BNE -> branch_flag stays 0, ex_valid=0, state RUN. rst mid-stall -> all outputs 0.

Source files
------------

// File: rtl/id_fwd_stage_if.sv
// ID->EX boundary: decoded instruction and register reads in, resolved pipeline latch out.
// Latency: none (wires only).
// Backpressure: id_ready / ex_ready handshake signals are carried here.
interface id_fwd_stage_if #(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 5
);
   logic                      id_valid;
   logic                      id_ready;
   logic [ADDR_WIDTH-1:0]     id_pc;
   logic [1:0]                br_type;
   logic [ADDR_WIDTH-1:0]     br_target;
   logic                      rd_en_1;
   logic                      rd_en_2;
   logic [REG_ADDR_WIDTH-1:0] rd_addr_1;
   logic [REG_ADDR_WIDTH-1:0] rd_addr_2;
   logic [DATA_WIDTH-1:0]     rd_data_1;
   logic [DATA_WIDTH-1:0]     rd_data_2;
   logic                      ex_ready;
   logic                      ex_valid;
   logic [ADDR_WIDTH-1:0]     ex_pc;
   logic [DATA_WIDTH-1:0]     ex_op1;
   logic [DATA_WIDTH-1:0]     ex_op2;

   modport master (
      output id_valid, id_pc, br_type, br_target, rd_en_1, rd_en_2,
             rd_addr_1, rd_addr_2, rd_data_1, rd_data_2, ex_ready,
      input  id_ready, ex_valid, ex_pc, ex_op1, ex_op2
   );

   modport slave (
      input  id_valid, id_pc, br_type, br_target, rd_en_1, rd_en_2,
             rd_addr_1, rd_addr_2, rd_data_1, rd_data_2, ex_ready,
      output id_ready, ex_valid, ex_pc, ex_op1, ex_op2
   );
endinterface

// File: rtl/id_fwd_stage.sv
// Decode stage: N-channel operand forwarding, load-use stall, ID/EX latch, branch resolve (DELAY_SLOT_EN keeps the slot).
// Latency: 1 cycle ID->EX latch and ID->branch_flag; stall_request is combinational.
// Backpressure: holds the latch while ex_ready=0 and ex_valid=1; id_ready drops on hazard, flush or full latch.
module id_fwd_stage #(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 5,
   parameter int FWD_CH         = 2,
   parameter int CNT_WIDTH      = 16
) (
   input  logic                             clk,
   input  logic                             rst,
   id_fwd_stage_if.slave                    bus,
   input  logic [FWD_CH-1:0]                fwd_we,
   input  logic [FWD_CH-1:0]                fwd_load,
   input  logic [FWD_CH*REG_ADDR_WIDTH-1:0] fwd_addr,
   input  logic [FWD_CH*DATA_WIDTH-1:0]     fwd_data,
   input  logic                             flush,
   output logic                             stall_request,
   output logic                             branch_flag,
   output logic [ADDR_WIDTH-1:0]            branch_addr,
   output logic [CNT_WIDTH-1:0]             stall_cnt
);
   localparam logic [0:0] ST_RUN    = 1'b0;
   localparam logic [0:0] ST_SQUASH = 1'b1;

   typedef struct packed {
      logic                  hz;
      logic [DATA_WIDTH-1:0] val;
   } opnd_t;

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] pc;
      logic [DATA_WIDTH-1:0] op1;
      logic [DATA_WIDTH-1:0] op2;
   } ex_lat_t;

   function automatic opnd_t resolve(
      input logic                             en,
      input logic [REG_ADDR_WIDTH-1:0]        addr,
      input logic [DATA_WIDTH-1:0]            rf,
      input logic [FWD_CH-1:0]                we,
      input logic [FWD_CH-1:0]                ld,
      input logic [FWD_CH*REG_ADDR_WIDTH-1:0] fa,
      input logic [FWD_CH*DATA_WIDTH-1:0]     fd
   );
      opnd_t r;
      r.hz  = 1'b0;
      r.val = rf;
      // Walk oldest to youngest so the lowest matching channel is written last and wins
      for (int c = FWD_CH - 1; c >= 0; c--) begin
         if (we[c] && fa[c*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] == addr) begin
            r.hz  = ld[c];
            r.val = fd[c*DATA_WIDTH +: DATA_WIDTH];
         end
      end
      if (!en || addr == '0) begin
         r.hz  = 1'b0;
         r.val = '0;
      end
      return r;
   endfunction

   opnd_t      op1;
   opnd_t      op2;
   ex_lat_t    ex_lat;
   logic       ex_valid;
   logic       hazard;
   logic       advance;
   logic       id_ready;
   logic       squash;
   logic       taken;
   logic [0:0] state;

   always_comb begin
      op1 = resolve(bus.rd_en_1, bus.rd_addr_1, bus.rd_data_1, fwd_we, fwd_load, fwd_addr, fwd_data);
      op2 = resolve(bus.rd_en_2, bus.rd_addr_2, bus.rd_data_2, fwd_we, fwd_load, fwd_addr, fwd_data);
   end

   assign hazard        = bus.id_valid & (op1.hz | op2.hz);
   assign stall_request = hazard;
   assign advance       = bus.ex_ready | ~ex_valid;
   assign id_ready      = bus.id_valid & ~hazard & advance & ~flush;
   assign squash        = (state == ST_SQUASH);

   always_comb begin
      case (bus.br_type)
         2'd1:    taken = (op1.val == op2.val);
         2'd2:    taken = (op1.val != op2.val);
         2'd3:    taken = 1'b1;
         default: taken = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_valid    <= 1'b0;
         ex_lat      <= '0;
         branch_flag <= 1'b0;
         branch_addr <= '0;
         stall_cnt   <= '0;
         state       <= ST_RUN;
      end else begin
         branch_flag <= 1'b0;
         if (stall_request && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + 1'b1;
         end
         if (flush) begin
            ex_valid <= 1'b0;
            state    <= ST_RUN;
         end else begin
            if (advance) begin
               ex_valid <= id_ready & ~squash;
            end
            if (id_ready) begin
               ex_lat <= '{pc: bus.id_pc, op1: op1.val, op2: op2.val};
               // The squashed slot is still consumed, but is never evaluated as a branch
               if (squash) begin
                  state <= ST_RUN;
               end else if (taken) begin
                  branch_flag <= 1'b1;
                  branch_addr <= bus.br_target;
`ifndef DELAY_SLOT_EN
                  state       <= ST_SQUASH;
`endif
               end
            end
         end
      end
   end

   assign bus.id_ready = id_ready;
   assign bus.ex_valid = ex_valid;
   assign bus.ex_pc    = ex_lat.pc;
   assign bus.ex_op1   = ex_lat.op1;
   assign bus.ex_op2   = ex_lat.op2;
endmodule

// File: tb/tb_id_fwd_stage.sv
// Bench for id_fwd_stage: directed scenarios then randomized traffic against a behavioural model.
// Latency: checks every cycle at clk+1 after the falling edge.
// Backpressure: ex_ready is randomized to exercise latch hold.
module tb_id_fwd_stage;
   localparam int DW   = 32;
   localparam int AW   = 32;
   localparam int RW   = 5;
   localparam int NCH  = 3;
   localparam int CW   = 4;
   localparam int CMAX = (1 << CW) - 1;

   logic              clk = 1'b0;
   logic              rst;
   logic [NCH-1:0]    fwd_we;
   logic [NCH-1:0]    fwd_load;
   logic [NCH*RW-1:0] fwd_addr;
   logic [NCH*DW-1:0] fwd_data;
   logic              flush;
   logic              stall_request;
   logic              branch_flag;
   logic [AW-1:0]     branch_addr;
   logic [CW-1:0]     stall_cnt;

   int n_vec = 0;
   int n_err = 0;

   // Model of the architectural state
   bit          armed = 1'b0;
   bit          m_v;
   logic [AW-1:0] m_pc;
   logic [DW-1:0] m_op1;
   logic [DW-1:0] m_op2;
   bit          m_bf;
   logic [AW-1:0] m_baddr;
   int          m_cnt;
   bit          m_drop;

   always #5 clk = ~clk;

   id_fwd_stage_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REG_ADDR_WIDTH(RW)) bus ();

   id_fwd_stage #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REG_ADDR_WIDTH(RW), .FWD_CH(NCH), .CNT_WIDTH(CW)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus),
      .fwd_we(fwd_we), .fwd_load(fwd_load), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
      .flush(flush), .stall_request(stall_request), .branch_flag(branch_flag),
      .branch_addr(branch_addr), .stall_cnt(stall_cnt)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic resolve(input logic en, input logic [RW-1:0] a, input logic [DW-1:0] rf,
                          output bit hz, output logic [DW-1:0] v);
      hz = 1'b0;
      v  = rf;
      if (!en || a == '0) begin
         v = '0;
         return;
      end
      for (int c = 0; c < NCH; c++) begin
         if (fwd_we[c] && fwd_addr[c*RW +: RW] == a) begin
            hz = fwd_load[c];
            v  = fwd_data[c*DW +: DW];
            return;
         end
      end
   endtask

   task automatic model_cycle();
      bit h1, h2, e_st, e_adv, e_rdy, tk;
      logic [DW-1:0] v1, v2;
      resolve(bus.rd_en_1, bus.rd_addr_1, bus.rd_data_1, h1, v1);
      resolve(bus.rd_en_2, bus.rd_addr_2, bus.rd_data_2, h2, v2);
      e_st  = bus.id_valid && (h1 || h2);
      e_adv = bus.ex_ready || !m_v;
      e_rdy = bus.id_valid && !e_st && e_adv && !flush;
      if (armed) begin
         chk("stall_request", 32'(stall_request), 32'(e_st));
         chk("id_ready", 32'(bus.id_ready), 32'(e_rdy));
         chk("ex_valid", 32'(bus.ex_valid), 32'(m_v));
         chk("ex_pc", bus.ex_pc, m_pc);
         chk("ex_op1", bus.ex_op1, m_op1);
         chk("ex_op2", bus.ex_op2, m_op2);
         chk("branch_flag", 32'(branch_flag), 32'(m_bf));
         chk("branch_addr", branch_addr, m_baddr);
         chk("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
      end
      tk = (bus.br_type == 2'd3) || (bus.br_type == 2'd1 && v1 == v2) ||
           (bus.br_type == 2'd2 && v1 != v2);
      if (rst) begin
         armed = 1'b1;
         m_v = 1'b0; m_pc = '0; m_op1 = '0; m_op2 = '0;
         m_bf = 1'b0; m_baddr = '0; m_cnt = 0; m_drop = 1'b0;
      end else begin
         if (e_st && m_cnt < CMAX) m_cnt++;
         m_bf = 1'b0;
         if (flush) begin
            m_v    = 1'b0;
            m_drop = 1'b0;
         end else begin
            if (e_adv) m_v = e_rdy && !m_drop;
            if (e_rdy) begin
               m_pc = bus.id_pc; m_op1 = v1; m_op2 = v2;
               if (m_drop) begin
                  m_drop = 1'b0;
               end else if (tk) begin
                  m_bf    = 1'b1;
                  m_baddr = bus.br_target;
`ifndef DELAY_SLOT_EN
                  m_drop  = 1'b1;
`endif
               end
            end
         end
      end
   endtask

   task automatic cyc();
      #1;
      model_cycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic set_ch(input int c, input bit we, input bit ld, input logic [RW-1:0] a,
                         input logic [DW-1:0] d);
      fwd_we[c]           = we;
      fwd_load[c]         = ld;
      fwd_addr[c*RW +: RW] = a;
      fwd_data[c*DW +: DW] = d;
   endtask

   task automatic idle();
      bus.id_valid = 1'b0; bus.id_pc = '0; bus.br_type = 2'd0; bus.br_target = '0;
      bus.rd_en_1 = 1'b0; bus.rd_en_2 = 1'b0; bus.rd_addr_1 = '0; bus.rd_addr_2 = '0;
      bus.rd_data_1 = '0; bus.rd_data_2 = '0; bus.ex_ready = 1'b1;
      fwd_we = '0; fwd_load = '0; fwd_addr = '0; fwd_data = '0; flush = 1'b0;
   endtask

   task automatic instr(input logic [AW-1:0] pc, input bit e1, input logic [RW-1:0] a1,
                        input logic [DW-1:0] d1, input bit e2, input logic [RW-1:0] a2,
                        input logic [DW-1:0] d2, input logic [1:0] bt, input logic [AW-1:0] tgt);
      bus.id_valid = 1'b1; bus.id_pc = pc; bus.br_type = bt; bus.br_target = tgt;
      bus.rd_en_1 = e1; bus.rd_addr_1 = a1; bus.rd_data_1 = d1;
      bus.rd_en_2 = e2; bus.rd_addr_2 = a2; bus.rd_data_2 = d2;
   endtask

   task automatic clr_fwd();
      fwd_we = '0; fwd_load = '0; fwd_addr = '0; fwd_data = '0;
   endtask

   initial begin
      idle();
      rst = 1'b1;
      @(negedge clk);
      cyc();
      rst = 1'b0;
      chk("rst_ex_valid", 32'(bus.ex_valid), 32'd0);
      chk("rst_ex_pc", bus.ex_pc, 32'd0);
      chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
      chk("rst_branch_flag", 32'(branch_flag), 32'd0);

      // Forwarding priority: youngest channel first, then older, then register file
      instr(32'h10, 1'b1, 5'd3, 32'h55, 1'b0, 5'd0, 32'h0, 2'd0, 32'h0);
      set_ch(0, 1'b1, 1'b0, 5'd3, 32'h11);
      set_ch(1, 1'b1, 1'b0, 5'd3, 32'h22);
      cyc();
      chk("fwd_ch0", bus.ex_op1, 32'h11);
      chk("fwd_ch0_valid", 32'(bus.ex_valid), 32'd1);
      set_ch(0, 1'b0, 1'b0, 5'd3, 32'h11);
      bus.id_pc = 32'h14;
      cyc();
      chk("fwd_ch1", bus.ex_op1, 32'h22);
      set_ch(1, 1'b0, 1'b0, 5'd3, 32'h22);
      cyc();
      chk("fwd_rf", bus.ex_op1, 32'h55);

      // Load-use stall for two cycles
      clr_fwd();
      instr(32'h20, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'h99, 2'd0, 32'h0);
      set_ch(0, 1'b1, 1'b1, 5'd5, 32'h77);
      for (int i = 0; i < 2; i++) begin
         #1;
         chk("lu_stall", 32'(stall_request), 32'd1);
         chk("lu_id_ready", 32'(bus.id_ready), 32'd0);
         cyc();
      end
      chk("lu_bubble", 32'(bus.ex_valid), 32'd0);
      chk("lu_cnt", 32'(stall_cnt), 32'd2);
      set_ch(0, 1'b1, 1'b0, 5'd5, 32'h77);
      cyc();
      chk("lu_accept", 32'(bus.ex_valid), 32'd1);
      chk("lu_op2", bus.ex_op2, 32'h77);
      chk("lu_pc", bus.ex_pc, 32'h20);

      // r0 is never forwarded and never stalls
      clr_fwd();
      instr(32'h30, 1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 32'h0, 2'd0, 32'h0);
      set_ch(0, 1'b1, 1'b1, 5'd0, 32'hFFFF_FFFF);
      #1;
      chk("r0_nostall", 32'(stall_request), 32'd0);
      cyc();
      chk("r0_op1", bus.ex_op1, 32'd0);
      chk("r0_cnt", 32'(stall_cnt), 32'd2);

      // BEQ taken on forwarded operands
      clr_fwd();
      instr(32'h40, 1'b1, 5'd1, 32'd1, 1'b1, 5'd2, 32'd2, 2'd1, 32'h100);
      set_ch(0, 1'b1, 1'b0, 5'd1, 32'd7);
      set_ch(1, 1'b1, 1'b0, 5'd2, 32'd7);
      cyc();
      chk("beq_flag", 32'(branch_flag), 32'd1);
      chk("beq_addr", branch_addr, 32'h100);
      clr_fwd();
      instr(32'h44, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 2'd0, 32'h0);
      cyc();
`ifdef DELAY_SLOT_EN
      chk("slot_valid", 32'(bus.ex_valid), 32'd1);
`else
      chk("slot_valid", 32'(bus.ex_valid), 32'd0);
`endif
      chk("beq_pulse", 32'(branch_flag), 32'd0);
      chk("slot_pc", bus.ex_pc, 32'h44);
      bus.id_pc = 32'h48;
      cyc();
      chk("post_slot_valid", 32'(bus.ex_valid), 32'd1);

      // Backpressure holds the latch
      bus.id_pc = 32'h300;
      cyc();
      chk("bp_load", bus.ex_pc, 32'h300);
      bus.ex_ready = 1'b0;
      bus.id_pc = 32'h304;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("bp_id_ready", 32'(bus.id_ready), 32'd0);
         cyc();
         chk("bp_hold_pc", bus.ex_pc, 32'h300);
      end
      bus.ex_ready = 1'b1;
      cyc();
      chk("bp_release", bus.ex_pc, 32'h304);

      // Flush drops a same-cycle branch and returns to RUN
      instr(32'h500, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 2'd3, 32'h600);
      cyc();
      chk("jmp_addr", branch_addr, 32'h600);
      flush = 1'b1;
      instr(32'h504, 1'b1, 5'd1, 32'd1, 1'b1, 5'd2, 32'd2, 2'd2, 32'h700);
      cyc();
      chk("flush_flag", 32'(branch_flag), 32'd0);
      chk("flush_valid", 32'(bus.ex_valid), 32'd0);
      chk("flush_addr", branch_addr, 32'h600);
      flush = 1'b0;
      instr(32'h508, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 2'd0, 32'h0);
      cyc();
      chk("flush_run", 32'(bus.ex_valid), 32'd1);

      // Reset in the middle of a stall
      instr(32'h600, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'h0, 2'd0, 32'h0);
      set_ch(0, 1'b1, 1'b1, 5'd5, 32'h1);
      cyc();
      chk("pre_rst_cnt", 32'(stall_cnt), 32'd3);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      chk("mid_rst_cnt", 32'(stall_cnt), 32'd0);
      chk("mid_rst_valid", 32'(bus.ex_valid), 32'd0);
      chk("mid_rst_op1", bus.ex_op1, 32'd0);
      chk("mid_rst_baddr", branch_addr, 32'd0);

      // Counter saturation
      for (int i = 0; i < 20; i++) cyc();
      chk("cnt_sat", 32'(stall_cnt), 32'(CMAX));

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         bus.id_valid  = ($urandom_range(0, 9) != 0);
         bus.id_pc     = $urandom;
         bus.br_type   = 2'($urandom_range(0, 3));
         bus.br_target = $urandom;
         bus.rd_en_1   = ($urandom_range(0, 7) != 0);
         bus.rd_en_2   = ($urandom_range(0, 7) != 0);
         bus.rd_addr_1 = RW'($urandom_range(0, 3));
         bus.rd_addr_2 = RW'($urandom_range(0, 3));
         bus.rd_data_1 = $urandom_range(0, 3);
         bus.rd_data_2 = $urandom_range(0, 3);
         for (int c = 0; c < NCH; c++) begin
            set_ch(c, ($urandom_range(0, 1) == 1), ($urandom_range(0, 5) == 0),
                   RW'($urandom_range(0, 3)), $urandom_range(0, 3));
         end
         bus.ex_ready = ($urandom_range(0, 3) != 0);
         flush        = ($urandom_range(0, 19) == 0);
         rst          = ($urandom_range(0, 299) == 0);
         cyc();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
